// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, branch types, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mc_pkg;

  // Encodings 5 and 6 are unused and treated as illegal by the sequencer.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERROR  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_t;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 32;

endpackage

// File: rtl/mc_mem_watchdog.sv
// Memory wait-cycle counter shared by instruction-fetch and data accesses.
// Latency: at_limit is combinational from the registered count.
// Backpressure: none; it only observes the request/ready handshake.
module mc_mem_watchdog
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic wait_cyc,
  output logic at_limit
);

  // The count never exceeds MEM_TIMEOUT-1: the sequencer leaves the waiting state on that cycle.
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Count unanswered request cycles; restart whenever the sequencer enters a new state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (wait_cyc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // One more unanswered cycle reaches the limit; a same-cycle Mem_Ready still wins upstream.
  assign at_limit = (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM owning the shared memory port; MC_SEQ_STALL_CNT_EN adds Stall_Cycles.
// Latency: ALU 4, load 5, store 4, branch 3 cycles with zero-wait memory; strobes are combinational from state.
// Backpressure: Mem_Req is held until Mem_Ready; Freeze only delays the start of a fetch; a stuck request ends in ERROR.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Freeze,
  input  logic             Mem_Ready,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  input  logic             WB_EN,
  input  logic [1:0]       Br_type,
  input  logic             Br_taken,
  output logic             Mem_Req,
  output logic             Mem_Is_Fetch,
  output logic             Mem_Write,
  output logic             IF_Latch,
  output logic             PC_Write,
  output logic             PC_Sel_Branch,
  output logic             ID_Latch,
  output logic             EXE_Latch,
  output logic             WB_Write_Enable,
  output logic [2:0]       State,
  output logic             Error,
`ifdef MC_SEQ_STALL_CNT_EN
  output logic [CNT_W-1:0] Stall_Cycles,
`endif
  output logic [CNT_W-1:0] Retired
);

  state_t state_q;
  state_t state_nxt;
  logic   req_pend_q;
  logic   retire;
  logic   wait_cyc;
  logic   at_limit;

  assign wait_cyc = Mem_Req && !Mem_Ready;
  assign State    = state_q;
  assign Error    = (state_q == ST_ERROR);

  mc_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_nxt != state_q),
    .wait_cyc(wait_cyc),
    .at_limit(at_limit)
  );

  // Decode the current state into strobes, memory handshake and next state.
  always_comb begin
    Mem_Req         = 1'b0;
    Mem_Is_Fetch    = 1'b0;
    Mem_Write       = 1'b0;
    IF_Latch        = 1'b0;
    PC_Write        = 1'b0;
    PC_Sel_Branch   = 1'b0;
    ID_Latch        = 1'b0;
    EXE_Latch       = 1'b0;
    WB_Write_Enable = 1'b0;
    retire          = 1'b0;
    state_nxt       = state_q;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          // Freeze only matters before the fetch request has been raised.
          if (req_pend_q || !Freeze) begin
            Mem_Req      = 1'b1;
            Mem_Is_Fetch = 1'b1;
            if (Mem_Ready) begin
              IF_Latch  = 1'b1;
              PC_Write  = 1'b1;
              state_nxt = ST_DECODE;
            end else if (at_limit) begin
              state_nxt = ST_ERROR;
            end
          end
        end
        ST_DECODE: begin
          ID_Latch  = 1'b1;
          state_nxt = ST_EXEC;
        end
        ST_EXEC: begin
          EXE_Latch = 1'b1;
          if (Br_type != BR_NONE) begin
            // Branches never touch memory or the register file.
            if (Br_type == BR_JMP || Br_taken) begin
              PC_Write      = 1'b1;
              PC_Sel_Branch = 1'b1;
            end
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end else if (MEM_R_EN || MEM_W_EN) begin
            state_nxt = ST_MEM;
          end else if (WB_EN) begin
            state_nxt = ST_WB;
          end else begin
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
        ST_MEM: begin
          Mem_Req   = 1'b1;
          Mem_Write = MEM_W_EN;
          if (Mem_Ready) begin
            // A simultaneous read+write is a store, so it never writes back.
            if (MEM_R_EN && !MEM_W_EN && WB_EN) begin
              state_nxt = ST_WB;
            end else begin
              retire    = 1'b1;
              state_nxt = ST_FETCH;
            end
          end else if (at_limit) begin
            state_nxt = ST_ERROR;
          end
        end
        ST_WB: begin
          WB_Write_Enable = 1'b1;
          retire          = 1'b1;
          state_nxt       = ST_FETCH;
        end
        ST_ERROR: begin
          state_nxt = ST_ERROR;
        end
        default: begin
          state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  // State, outstanding-fetch flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      req_pend_q <= 1'b0;
      Retired    <= '0;
    end else begin
      state_q    <= state_nxt;
      req_pend_q <= wait_cyc && (state_q == ST_FETCH);
      if (retire) begin
        Retired <= Retired + CNT_W'(1);
      end
    end
  end

`ifdef MC_SEQ_STALL_CNT_EN
  // Count cycles lost to memory waits or to Freeze holding off a fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_Cycles <= '0;
    end else if (wait_cyc || (state_q == ST_FETCH && Freeze)) begin
      Stall_Cycles <= Stall_Cycles + CNT_W'(1);
    end
  end
`else
  // Stall accounting is not built in this configuration.
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized scoreboard bench for mc_sequencer with a 4-bit retired counter and a 4-cycle memory timeout.
// Latency: expected per-cycle outputs are queued as each cycle is driven and checked 2 ns later.
// Backpressure: Mem_Ready waits and Freeze are drawn at random within each instruction plan.
module tb_mc_sequencer;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  // Strobe vector: {Mem_Req, Mem_Is_Fetch, Mem_Write, IF_Latch, PC_Write, PC_Sel_Branch, ID_Latch, EXE_Latch, WB_Write_Enable}
  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] REQ_F = 9'b110000000;
  localparam logic [8:0] F_ACK = 9'b110110000;
  localparam logic [8:0] ID    = 9'b000000100;
  localparam logic [8:0] EXE   = 9'b000000010;
  localparam logic [8:0] BRJ   = 9'b000011010;
  localparam logic [8:0] REQ_D = 9'b100000000;
  localparam logic [8:0] MW    = 9'b001000000;
  localparam logic [8:0] WBE   = 9'b000000001;

  logic clk = 1'b0;
  logic rst, Freeze, Mem_Ready, MEM_R_EN, MEM_W_EN, WB_EN, Br_taken;
  logic [1:0] Br_type;
  logic Mem_Req, Mem_Is_Fetch, Mem_Write, IF_Latch, PC_Write, PC_Sel_Branch;
  logic ID_Latch, EXE_Latch, WB_Write_Enable, Error;
  logic [2:0] State;
  logic [CNT_W-1:0] Retired;
`ifdef MC_SEQ_STALL_CNT_EN
  logic [CNT_W-1:0] Stall_Cycles;
`endif

  mc_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .Freeze(Freeze), .Mem_Ready(Mem_Ready),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
    .Br_type(Br_type), .Br_taken(Br_taken),
    .Mem_Req(Mem_Req), .Mem_Is_Fetch(Mem_Is_Fetch), .Mem_Write(Mem_Write),
    .IF_Latch(IF_Latch), .PC_Write(PC_Write), .PC_Sel_Branch(PC_Sel_Branch),
    .ID_Latch(ID_Latch), .EXE_Latch(EXE_Latch), .WB_Write_Enable(WB_Write_Enable),
    .State(State), .Error(Error),
`ifdef MC_SEQ_STALL_CNT_EN
    .Stall_Cycles(Stall_Cycles),
`endif
    .Retired(Retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]       strb;
    logic             chk;
    logic [2:0]       st;
    logic             err;
    logic [CNT_W-1:0] ret;
    logic [CNT_W-1:0] stall;
    int               tag;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int tag   = 0;

  // Reference model state: instruction counts and stall counts as plain wrapping counters.
  logic [CNT_W-1:0] m_ret   = '0;
  logic [CNT_W-1:0] m_stall = '0;
  logic             m_known = 1'b0;

  // Decoded controls for the instruction currently being driven.
  logic n_r, n_w, n_wb, n_tk;
  logic [1:0] n_br;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle and queue what the outputs must be during it.
  task automatic cyc(input logic r, input logic f, input logic rdy,
                     input logic [8:0] strb, input logic [2:0] st, input logic do_ret);
    exp_t e;
    @(negedge clk);
    rst = r; Freeze = f; Mem_Ready = rdy;
    MEM_R_EN = n_r; MEM_W_EN = n_w; WB_EN = n_wb; Br_type = n_br; Br_taken = n_tk;
    e.strb = strb; e.chk = m_known; e.st = st; e.err = (st == 3'd7);
    e.ret = m_ret; e.stall = m_stall; e.tag = tag;
    q.push_back(e);
    if (r) begin
      m_ret = '0; m_stall = '0; m_known = 1'b1;
    end else begin
      if (do_ret) m_ret = m_ret + 1'b1;
      if ((strb[8] && !rdy) || (st == 3'd0 && f)) m_stall = m_stall + 1'b1;
    end
  endtask

  // Hold in ERROR for a few cycles, then a single reset cycle.
  task automatic error_and_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, rb(), rb(), NONE, 3'd7, 1'b0);
    cyc(1'b1, rb(), rb(), NONE, 3'd7, 1'b0);
  endtask

  // kind: 0 ALU+WB, 1 ALU no WB, 2 load+WB, 3 load no WB, 4 store, 5 R&W+WB, 6 branch.
  // A wait of TMO unanswered cycles means the access times out.
  task automatic run_instr(input int kind, input int nfrz, input int wf, input int wd,
                           input logic [1:0] br, input logic tk);
    logic [8:0] s;
    logic need_wb;
    n_tk = tk; n_br = 2'd0;
    case (kind)
      0: {n_r, n_w, n_wb} = 3'b001;
      1: {n_r, n_w, n_wb} = 3'b000;
      2: {n_r, n_w, n_wb} = 3'b101;
      3: {n_r, n_w, n_wb} = 3'b100;
      4: {n_r, n_w, n_wb} = 3'b010;
      5: {n_r, n_w, n_wb} = 3'b111;
      default: begin {n_r, n_w, n_wb} = 3'($urandom_range(0, 7)); n_br = br; end
    endcase
    tag++;
    for (int i = 0; i < nfrz; i++) cyc(1'b0, 1'b1, rb(), NONE, 3'd0, 1'b0);
    for (int i = 0; i < wf; i++) cyc(1'b0, (i == 0) ? 1'b0 : rb(), 1'b0, REQ_F, 3'd0, 1'b0);
    if (wf >= TMO) begin error_and_reset(); return; end
    cyc(1'b0, (wf == 0) ? 1'b0 : rb(), 1'b1, F_ACK, 3'd0, 1'b0);
    cyc(1'b0, rb(), rb(), ID, 3'd1, 1'b0);
    if (n_br != 2'd0) begin
      s = (n_br == 2'd3 || n_tk) ? BRJ : EXE;
      cyc(1'b0, rb(), rb(), s, 3'd2, 1'b1);
      return;
    end
    if (!(n_r || n_w)) begin
      cyc(1'b0, rb(), rb(), EXE, 3'd2, !n_wb);
      if (n_wb) cyc(1'b0, rb(), rb(), WBE, 3'd4, 1'b1);
      return;
    end
    cyc(1'b0, rb(), rb(), EXE, 3'd2, 1'b0);
    s = REQ_D | (n_w ? MW : NONE);
    for (int i = 0; i < wd; i++) cyc(1'b0, rb(), 1'b0, s, 3'd3, 1'b0);
    if (wd >= TMO) begin error_and_reset(); return; end
    need_wb = n_r && !n_w && n_wb;
    cyc(1'b0, rb(), 1'b1, s, 3'd3, !need_wb);
    if (need_wb) cyc(1'b0, rb(), rb(), WBE, 3'd4, 1'b1);
  endtask

  // Reset arriving while an ALU instruction is in EXEC: no strobes, nothing retired.
  task automatic reset_mid_instr();
    {n_r, n_w, n_wb} = 3'b001; n_br = 2'd0; n_tk = 1'b0;
    tag++;
    cyc(1'b0, 1'b0, 1'b1, F_ACK, 3'd0, 1'b0);
    cyc(1'b0, rb(), rb(), ID, 3'd1, 1'b0);
    cyc(1'b1, rb(), rb(), NONE, 3'd2, 1'b0);
  endtask

  function automatic int pick_wait();
    int w;
    w = $urandom_range(0, 3);
    if ($urandom_range(0, 39) == 0) w = TMO;
    return w;
  endfunction

  // Monitor: pop one expectation per driven cycle and compare against the DUT outputs.
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {Mem_Req, Mem_Is_Fetch & Mem_Req, Mem_Write & Mem_Req, IF_Latch, PC_Write,
               PC_Sel_Branch & PC_Write, ID_Latch, EXE_Latch, WB_Write_Enable};
        n_cmp++;
        if (act !== e.strb) begin
          n_bad++;
          $display("FAIL strobes instr=%0d t=%0t actual=%b required=%b", e.tag, $time, act, e.strb);
        end
        if (e.chk) begin
          n_cmp++;
          if ({State, Error, Retired} !== {e.st, e.err, e.ret}) begin
            n_bad++;
            $display("FAIL regs instr=%0d t=%0t actual state=%0d err=%b ret=%0d required state=%0d err=%b ret=%0d",
                     e.tag, $time, State, Error, Retired, e.st, e.err, e.ret);
          end
`ifdef MC_SEQ_STALL_CNT_EN
          n_cmp++;
          if (Stall_Cycles !== e.stall) begin
            n_bad++;
            $display("FAIL stall instr=%0d t=%0t actual=%0d required=%0d", e.tag, $time, Stall_Cycles, e.stall);
          end
`endif
        end
      end
    end
  end

  // Time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; Freeze = 1'b0; Mem_Ready = 1'b0;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN = 1'b0; Br_type = 2'd0; Br_taken = 1'b0;
    n_r = 1'b0; n_w = 1'b0; n_wb = 1'b0; n_br = 2'd0; n_tk = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, NONE, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, NONE, 3'd0, 1'b0);
    // Directed: ALU with zero-wait memory, delayed-data load, taken BNE, untaken BEZ, JMP.
    run_instr(0, 0, 0, 0, 2'd0, 1'b0);
    run_instr(2, 0, 0, 3, 2'd0, 1'b0);
    run_instr(6, 0, 0, 0, 2'd2, 1'b1);
    run_instr(6, 0, 0, 0, 2'd1, 1'b0);
    run_instr(6, 0, 1, 0, 2'd3, 1'b0);
    // Store, then a fetch held off by Freeze; read+write treated as store.
    run_instr(4, 0, 0, 2, 2'd0, 1'b0);
    run_instr(0, 3, 0, 0, 2'd0, 1'b0);
    run_instr(5, 0, 3, 3, 2'd0, 1'b0);
    // Timeouts in fetch and in data access, each followed by reset.
    run_instr(0, 0, TMO, 0, 2'd0, 1'b0);
    run_instr(1, 0, 0, 0, 2'd0, 1'b0);
    run_instr(3, 0, 0, TMO, 2'd0, 1'b0);
    reset_mid_instr();
    // 17 stores with two waits per access: counters wrap at 16.
    for (int i = 0; i < 17; i++) run_instr(4, 0, 2, 2, 2'd0, 1'b0);
    // Random mix.
    for (int i = 0; i < 200; i++) begin
      run_instr($urandom_range(0, 6),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                pick_wait(), pick_wait(), 2'($urandom_range(1, 3)), rb());
    end
    @(negedge clk);
    @(negedge clk);
    #5;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multicycle control FSM that sequences one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
- Drives the latch and write enables of the IF/ID/EXE/MEM/WB datapath.
- Consumes decoded controls (MEM_R_EN, MEM_W_EN, WB_EN, Br_type) and the branch compare result.
- Owns the single shared memory port handshake. Sits beside the decode stage; all stage registers are gated only by its strobes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 255, maximum cycles a memory request may wait for Mem_Ready before the FSM enters ERROR (must be ≥ 1).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Freeze  in  1  hold off new fetches
- Mem_Ready  in  1  memory acknowledges the current request this cycle
- MEM_R_EN  in  1  decoded: instruction loads
- MEM_W_EN  in  1  decoded: instruction stores
- WB_EN  in  1  decoded: instruction writes a register
- Br_type  in  2  0 none, 1 BEZ, 2 BNE, 3 JMP
- Br_taken  in  1  branch compare result, valid in EXEC
- Mem_Req  out  1  memory request, level
- Mem_Is_Fetch  out  1  current request is an instruction fetch
- Mem_Write  out  1  current request is a store
- IF_Latch  out  1  capture the instruction register
- PC_Write  out  1  update PC
- PC_Sel_Branch  out  1  PC source: 1 = branch target, 0 = PC+4
- ID_Latch  out  1  capture register-file outputs and Val2/Dest
- EXE_Latch  out  1  capture ALU result
- WB_Write_Enable  out  1  register-file write strobe
- State  out  3  current FSM state encoding
- Error  out  1  sticky memory-timeout flag
- Retired  out  CNT_W  count of completed instructions

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7. Encodings 5 and 6 are illegal and go to FETCH on the next cycle.
- Reset: rst high → state FETCH, Retired=0, Error=0, wait counter=0. All strobes and Mem_Req are 0 while rst is high. Reset mid-instruction abandons the instruction with no writes.
- All strobes except Mem_Req are single-cycle pulses, combinational from state and inputs.
- FETCH:
  - Freeze=1 → Mem_Req=0, remain in FETCH.
  - Otherwise Mem_Req=1 and Mem_Is_Fetch=1.
  - When Mem_Ready=1 in the same cycle: IF_Latch=1, PC_Write=1 with PC_Sel_Branch=0, go to DECODE.
  - Freeze is sampled only when no request is outstanding. Once Mem_Req rises it stays high until Mem_Ready.
- DECODE: ID_Latch=1, go to EXEC.
- EXEC: EXE_Latch=1. Next state is chosen in this priority:
  - Br_type≠0: if Br_type=3 or Br_taken=1, PC_Write=1 with PC_Sel_Branch=1. Retire and go to FETCH. Memory and WB controls are ignored.
  - MEM_R_EN or MEM_W_EN → MEM.
  - WB_EN → WB.
  - Otherwise retire and go to FETCH.
- MEM: Mem_Req=1, Mem_Is_Fetch=0, Mem_Write=MEM_W_EN. On Mem_Ready:
  - load with WB_EN → WB;
  - otherwise retire and go to FETCH.
  - If MEM_R_EN and MEM_W_EN are both 1, the access is treated as a store.
- WB: WB_Write_Enable=1, retire, go to FETCH.
- Retire means Retired increments by 1 on that edge and wraps modulo 2^CNT_W.
- Minimum latency with zero-wait memory: ALU 4 cycles, load 5, store 4, branch 3.
- Mem_Ready while Mem_Req=0 is ignored.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle Mem_Req=1 and Mem_Ready=0.
  - Reaching MEM_TIMEOUT → ERROR on the next edge.
  - ERROR: all strobes 0, Error=1, held until rst.
  - Mem_Ready arriving in the same cycle the counter reaches MEM_TIMEOUT wins: the handshake completes normally.

Optional Feature:
- Macro: MC_SEQ_STALL_CNT_EN.
- Defined: adds output Stall_Cycles [CNT_W-1:0], which increments each cycle Mem_Req=1 and Mem_Ready=0, or state=FETCH with Freeze=1. It resets to 0 and wraps.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings (FETCH..ERROR);
  - Br_type encodings (BR_NONE, BR_BEZ, BR_BNE, BR_JMP);
  - default MEM_TIMEOUT.
- One natural sub-module, mc_mem_watchdog: the wait counter plus timeout compare, reused for fetch and data accesses.

Test Plan:
- ALU op (WB_EN=1, others 0), Mem_Ready tied 1 from reset release → pulses IF_Latch/PC_Write, ID_Latch, EXE_Latch, WB_Write_Enable on cycles 1–4; Retired=1 after cycle 4.
- Load (MEM_R_EN=1, WB_EN=1), data Mem_Ready delayed 3 cycles → Mem_Req high 4 cycles in MEM with Mem_Write=0; then WB pulse; 8 cycles total; Retired increments once.
- BNE with Br_taken=1, then BEZ with Br_taken=0 → first gives PC_Write with PC_Sel_Branch=1 in EXEC; second gives no PC_Write in EXEC; both return to FETCH after 3 cycles.
- Store while Freeze=1 is asserted during MEM → store completes with Mem_Write=1. The next FETCH holds Mem_Req=0 until Freeze=0.
- MEM_TIMEOUT=4, Mem_Ready held 0 in FETCH → ERROR after 4 stall cycles, Error=1, strobes stay 0. Then rst for 1 cycle → FETCH, Error=0, Retired=0.
- CNT_W=4 with 17 back-to-back stores → Retired wraps to 1. With MC_SEQ_STALL_CNT_EN and 2 wait cycles per access, Stall_Cycles=68 mod 16=4.
